mxv_seq_ctrl: RTL and testbench
===============================

# mxv_seq_ctrl

Sequenced matrix-vector engine controller. Accepts a vector, matrix and bias as one word stream, computes `result[j] = b[j] + Σ_i vector[i]*matrix[i][j]` with a single time-shared MAC, and streams the results out. It is the sequencing and buffering front end that lets the matrix-vector datapath sit behind a narrow valid/ready bus instead of wide parallel arrays.

## Interface
Parameters:
- `ROWS`, default 3: matrix rows; equals the vector length.
- `COLS`, default 5: matrix columns; equals the result and bias length.
- `DW`, default 32: signed data width for all words.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `abort`  in  1  synchronous flush; discards the current job.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid && in_ready`.
- `in_data`  in  DW  signed input word.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  result consumer ready.
- `out_data`  out  DW  signed result word.
- `out_last`  out  1  high with `result[COLS-1]`.
- `busy`  out  1  a job is in progress (any word accepted, not yet drained).

## Operation
- States: LOAD, CALC, DRAIN.
- **LOAD**
  - `in_ready = (state==LOAD) && !abort && rst_n`.
  - Accepted words, in order: `vector[0..ROWS-1]`, then the matrix row-major (`matrix[0][0..COLS-1]`, then `matrix[1][...]`, …), then `b[0..COLS-1]`.
  - Total `N = ROWS + ROWS*COLS + COLS` words; this is 23 at the defaults.
  - Word counter `ld_cnt` runs 0..N-1.
  - On acceptance of word N-1: go to CALC and clear `ld_cnt`.
- **CALC**
  - Runs ROWS*COLS cycles with step `k`, where `j = k / ROWS` and `i = k % ROWS`. Implement as nested counters, not a divider.
  - `i==0`: `acc <= b[j] + vector[0]*matrix[0][j]`.
  - Otherwise: `acc <= acc + vector[i]*matrix[i][j]`.
  - `i==ROWS-1`: also write the new acc value into `res[j]`.
  - After the final step: go to DRAIN with `out_idx=0`.
- **DRAIN**
  - `out_valid=1`, `out_data=res[out_idx]`, `out_last=(out_idx==COLS-1)`.
  - On `out_ready`: `out_idx++`.
  - On the handshake with `out_last`: go to LOAD.
- **Arithmetic**
  - Each product is the full signed DW×DW product truncated to its low DW bits.
  - All sums wrap modulo 2^DW.
  - No saturation and no overflow flag.
- **busy**: `(state!=LOAD) || (ld_cnt!=0)`.
- **abort**
  - Effective in any state: next state LOAD, all counters cleared.
  - Stored operands need not be cleared.
  - A word presented in the abort cycle is not accepted, because `in_ready` is low.
  - Abort overrides a simultaneous output handshake; the consumer must treat that handshake as void.
- **Input backpressure**: `in_valid` outside LOAD is ignored (`in_ready=0`). Gaps in `in_valid` during LOAD simply stall the count.
- **Output backpressure**: `out_ready` low holds `out_data`, `out_last` and `out_idx` stable.

## Timing
- Reset: while `rst_n`=0 at an edge, the next state is LOAD with all counters 0.
  - Output values after that edge: `in_ready=1` (0 while `rst_n` is low), `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`.
  - Reset mid-job behaves as abort.
- Let cycle T be the cycle in which the last input word is accepted.
  - CALC occupies cycles T+1 .. T+ROWS*COLS.
  - The first `out_valid` is at cycle T+ROWS*COLS+1; this is T+16 at the defaults.
- With `out_ready` held high, DRAIN lasts COLS cycles.
- `in_ready` rises in the cycle after the `out_last` handshake.
- Minimum job period: N + ROWS*COLS + COLS cycles, which is 43 at the defaults.
- No combinational path from `in_valid` or `out_ready` to any output.
  - Exception: `in_ready` depends combinationally on `abort` and `rst_n` only.

## Structure
- Package `mxv_pkg` holds:
  - the defaults `MXV_ROWS=3`, `MXV_COLS=5`, `MXV_DW=32`;
  - `typedef enum logic [1:0] {LOAD, CALC, DRAIN} mxv_state_t`;
  - `typedef logic signed [MXV_DW-1:0] mxv_word_t`.
- Operand and result storage are flip-flop arrays: `vec[ROWS]`, `mat[ROWS][COLS]`, `bias[COLS]`, `res[COLS]`.
- Sub-module `mxv_mac`: registered multiply-accumulate with inputs `a`, `b`, `addend`, `sel_init` and `en`, output `acc`. It is the only multiplier in the block.

## Test plan
- **Nominal job.** Stream 1,2,3 | 1..15 | 1,2,3,4,5 with `out_ready=1`. Required: outputs 47, 54, 61, 68, 75; `out_last` only on 75; first `out_valid` 16 cycles after the last input is accepted.
- **Signed and wrap.** Vector {-1,0,0}, matrix row0 = {0x80000000, 5, -7, 0, 1}, zero bias. Required: outputs 0x80000000, -5, 7, 0, -1.
- **Output backpressure.** Nominal job with `out_ready` toggling 1,0,0,1 repeatedly. Required: each word is held unchanged while stalled, all five appear in order, and `in_ready` stays 0 until after the 75 handshake.
- **Input gaps and ignored input.** Random `in_valid` gaps during LOAD; `in_valid=1` with junk data during CALC and DRAIN. Required: identical results to the nominal job; junk is never accepted.
- **Abort.**
  - Abort after 10 words: `busy` falls next cycle, then a full nominal job yields 47..75.
  - Abort during DRAIN after 2 outputs: `out_valid` drops next cycle.
- **Reset mid-CALC.** `rst_n`=0 for one cycle. Required: next cycle shows all reset values and `in_ready=1`, and a following nominal job is correct.

Source files
------------

// File: rtl/mxv_pkg.sv
// Shared types and default sizes for the sequenced matrix-vector engine.
package mxv_pkg;

    localparam int MXV_ROWS = 3;
    localparam int MXV_COLS = 5;
    localparam int MXV_DW   = 32;

    typedef enum logic [1:0] {LOAD, CALC, DRAIN} mxv_state_t;

    typedef logic signed [MXV_DW-1:0] mxv_word_t;

endpackage

// File: rtl/mxv_mac.sv
// Registered multiply-accumulate: acc <= (sel_init ? addend : acc) + a*b, wrapping at DW bits.
module mxv_mac
    import mxv_pkg::*;
#(
    parameter int DW = MXV_DW
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 sel_init,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [DW-1:0] addend,
    output logic signed [DW-1:0] acc
);

    logic signed [DW-1:0] prod;
    logic signed [DW-1:0] acc_d;
    logic signed [DW-1:0] acc_q;

    // Only the low DW bits of the product are needed, so a DW-wide result suffices.
    assign prod  = a * b;
    assign acc_d = (sel_init ? addend : acc_q) + prod;

    always_ff @(posedge clk) begin
        if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mxv_seq_ctrl.sv
// Sequencing front end: loads vector/matrix/bias from one word stream, runs a
// time-shared MAC over every (row, column) pair, then drains the results.
module mxv_seq_ctrl
    import mxv_pkg::*;
#(
    parameter int ROWS = MXV_ROWS,
    parameter int COLS = MXV_COLS,
    parameter int DW   = MXV_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int N  = ROWS + ROWS * COLS + COLS;
    localparam int LW = $clog2(N);
    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [LW-1:0] LD_LAST = LW'(N - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(COLS - 1);

    mxv_state_t           state_q;
    logic [LW-1:0]        ld_cnt_q;
    logic [IW-1:0]        i_q;
    logic [CW-1:0]        j_q;
    logic [CW-1:0]        out_idx_q;
    logic [CW-1:0]        wr_col_q;
    logic                 wr_pend_q;

    logic signed [DW-1:0] vec_q  [ROWS];
    logic signed [DW-1:0] mat_q  [ROWS][COLS];
    logic signed [DW-1:0] bias_q [COLS];
    logic signed [DW-1:0] res_q  [COLS];

    logic                 flush;
    logic                 accept;
    logic                 mac_en;
    logic signed [DW-1:0] acc;

    assign flush    = !rst_n || abort;
    assign in_ready = (state_q == LOAD) && !abort && rst_n;
    assign accept   = in_valid && in_ready;
    assign mac_en   = (state_q == CALC) && !flush;

    mxv_mac #(.DW(DW)) u_mac (
        .clk      (clk),
        .en       (mac_en),
        .sel_init (i_q == '0),
        .a        (vec_q[i_q]),
        .b        (mat_q[i_q][j_q]),
        .addend   (bias_q[j_q]),
        .acc      (acc)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q   <= LOAD;
            ld_cnt_q  <= '0;
            i_q       <= '0;
            j_q       <= '0;
            out_idx_q <= '0;
            wr_col_q  <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            wr_pend_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (ld_cnt_q == LD_LAST) begin
                            ld_cnt_q <= '0;
                            state_q  <= CALC;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + LW'(1);
                        end
                    end
                end
                CALC: begin
                    // The column total lands in acc at this edge; commit it to res next cycle.
                    wr_pend_q <= (i_q == I_LAST);
                    wr_col_q  <= j_q;
                    if (i_q == I_LAST) begin
                        i_q <= '0;
                        if (j_q == C_LAST) begin
                            j_q       <= '0;
                            out_idx_q <= '0;
                            state_q   <= DRAIN;
                        end else begin
                            j_q <= j_q + CW'(1);
                        end
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_idx_q == C_LAST) begin
                            out_idx_q <= '0;
                            state_q   <= LOAD;
                        end else begin
                            out_idx_q <= out_idx_q + CW'(1);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                if (ld_cnt_q == LW'(r)) vec_q[r] <= in_data;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (ld_cnt_q == LW'(ROWS + r * COLS + c)) mat_q[r][c] <= in_data;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                if (ld_cnt_q == LW'(ROWS + ROWS * COLS + c)) bias_q[c] <= in_data;
            end
        end
        if (wr_pend_q) begin
            res_q[wr_col_q] <= acc;
        end
    end

    // Bypass covers the column whose res write is still pending when draining starts.
    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            if (wr_pend_q && (wr_col_q == out_idx_q)) begin
                out_data = acc;
            end else begin
                out_data = res_q[out_idx_q];
            end
        end
    end

    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && (out_idx_q == C_LAST);
    assign busy      = (state_q != LOAD) || (ld_cnt_q != '0);

endmodule

// File: tb/tb_mxv_seq_ctrl.sv
// Self-checking bench for mxv_seq_ctrl: table of jobs plus abort/reset sequences.
module tb_mxv_seq_ctrl;
    import mxv_pkg::*;

    localparam int ROWS = MXV_ROWS;
    localparam int COLS = MXV_COLS;
    localparam int DW   = MXV_DW;
    localparam int N    = ROWS + ROWS * COLS + COLS;
    localparam int NJOB = 8;

    logic          clk = 1'b0;
    logic          rst_n, abort, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [DW-1:0] in_data, out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mxv_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct {
        logic [ROWS-1:0][DW-1:0]      v;
        logic [ROWS*COLS-1:0][DW-1:0] m;
        logic [COLS-1:0][DW-1:0]      b;
        logic [COLS-1:0][DW-1:0]      r;
        int                           gap;
        int                           rdy;
        int                           junk;
    } vec_t;

    vec_t tbl [NJOB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COLS-1:0][DW-1:0] model(input vec_t t);
        logic [COLS-1:0][DW-1:0] res;
        for (int j = 0; j < COLS; j++) begin
            logic signed [DW-1:0] s;
            s = $signed(t.b[j]);
            for (int i = 0; i < ROWS; i++) begin
                s = s + $signed(t.v[i]) * $signed(t.m[i*COLS+j]);
            end
            res[j] = s;
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] word_of(input vec_t t, input int idx);
        if (idx < ROWS) return t.v[idx];
        else if (idx < ROWS + ROWS * COLS) return t.m[idx-ROWS];
        else return t.b[idx-ROWS-ROWS*COLS];
    endfunction

    task automatic feed(input vec_t t);
        int widx = 0;
        int cyc  = 0;
        while (widx < N && cyc < 200) begin
            in_valid = 1'b1;
            in_data  = word_of(t, widx);
            #2;
            if (in_ready) widx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("feed_words", widx, N);
    endtask

    task automatic run_job(input vec_t t, input string tag);
        int            widx, oidx, cyc, tlast;
        logic          seen, stalled, held_l;
        logic [DW-1:0] held_d;
        widx = 0; oidx = 0; cyc = 0; tlast = 0;
        seen = 1'b0; stalled = 1'b0; held_l = 1'b0; held_d = '0;
        while (oidx < COLS && cyc < 500) begin
            if (widx < N) begin
                in_valid = (t.gap != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data  = in_valid ? word_of(t, widx) : DW'($urandom);
            end else begin
                in_valid = (t.junk != 0);
                in_data  = DW'($urandom);
            end
            case (t.rdy)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            #2;
            if (widx < N) begin
                if (in_valid && in_ready) begin
                    widx++;
                    tlast = cyc;
                end
            end else begin
                chkb({tag, " in_ready_low"}, in_ready, 1'b0);
                chkb({tag, " busy_high"}, busy, 1'b1);
                if (out_valid && !seen) begin
                    seen = 1'b1;
                    chk({tag, " first_valid_latency"}, cyc - tlast, ROWS * COLS + 1);
                end
                if (stalled) begin
                    chk({tag, " hold_data"}, out_data, held_d);
                    chkb({tag, " hold_last"}, out_last, held_l);
                end
                if (out_valid && out_ready) begin
                    chk({tag, $sformatf(" out_data[%0d]", oidx)}, out_data, t.r[oidx]);
                    chkb({tag, $sformatf(" out_last[%0d]", oidx)}, out_last, oidx == COLS - 1);
                    oidx++;
                end
                stalled = out_valid && !out_ready;
                held_d  = out_data;
                held_l  = out_last;
            end
            tick();
            cyc++;
        end
        chk({tag, " words_out"}, oidx, COLS);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chkb({tag, " in_ready_after"}, in_ready, 1'b1);
        chkb({tag, " out_valid_after"}, out_valid, 1'b0);
        chkb({tag, " busy_after"}, busy, 1'b0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n, cyc;
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Job table: nominal, signed/wrap, backpressure, gaps+junk, then random jobs.
        for (int i = 0; i < ROWS; i++) tbl[0].v[i] = DW'(i + 1);
        for (int k = 0; k < ROWS * COLS; k++) tbl[0].m[k] = DW'(k + 1);
        for (int j = 0; j < COLS; j++) begin
            tbl[0].b[j] = DW'(j + 1);
            tbl[0].r[j] = DW'(47 + 7 * j);
        end
        tbl[0].gap = 0; tbl[0].rdy = 0; tbl[0].junk = 0;

        tbl[1].v[0] = 32'hFFFF_FFFF;
        tbl[1].v[1] = '0;
        tbl[1].v[2] = '0;
        for (int k = 0; k < ROWS * COLS; k++) tbl[1].m[k] = DW'($urandom);
        tbl[1].m[0] = 32'h8000_0000;
        tbl[1].m[1] = 32'd5;
        tbl[1].m[2] = 32'hFFFF_FFF9;
        tbl[1].m[3] = 32'd0;
        tbl[1].m[4] = 32'd1;
        tbl[1].b    = '0;
        tbl[1].r[0] = 32'h8000_0000;
        tbl[1].r[1] = 32'hFFFF_FFFB;
        tbl[1].r[2] = 32'd7;
        tbl[1].r[3] = 32'd0;
        tbl[1].r[4] = 32'hFFFF_FFFF;
        tbl[1].gap = 0; tbl[1].rdy = 0; tbl[1].junk = 0;

        tbl[2] = tbl[0];
        tbl[2].rdy = 1;
        tbl[3] = tbl[0];
        tbl[3].gap = 1; tbl[3].junk = 1;

        for (int t = 4; t < NJOB; t++) begin
            for (int i = 0; i < ROWS; i++) tbl[t].v[i] = DW'($urandom);
            for (int k = 0; k < ROWS * COLS; k++) tbl[t].m[k] = DW'($urandom);
            for (int j = 0; j < COLS; j++) tbl[t].b[j] = DW'($urandom);
            tbl[t].gap  = int'($urandom_range(0, 1));
            tbl[t].rdy  = int'($urandom_range(0, 2));
            tbl[t].junk = int'($urandom_range(0, 1));
            tbl[t].r    = model(tbl[t]);
        end

        tick();
        #2;
        chkb("rst_in_ready_low", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        #2;
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chkb("rst_out_last", out_last, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        tick();

        for (int t = 0; t < NJOB; t++) begin
            run_job(tbl[t], $sformatf("job%0d", t));
        end

        // Abort after ten words.
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = word_of(tbl[0], k);
            tick();
        end
        in_valid = 1'b0;
        #2;
        chkb("abort_load busy_before", busy, 1'b1);
        abort    = 1'b1;
        in_valid = 1'b1;
        #1;
        chkb("abort_load in_ready", in_ready, 1'b0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        #2;
        chkb("abort_load busy_after", busy, 1'b0);
        chkb("abort_load in_ready_after", in_ready, 1'b1);
        tick();
        run_job(tbl[0], "post_abort");

        // Abort in DRAIN after two outputs.
        feed(tbl[0]);
        out_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < 60) begin
            #2;
            if (out_valid) n++;
            tick();
            cyc++;
        end
        chk("abort_drain outputs_seen", n, 2);
        #2;
        chkb("abort_drain valid_before", out_valid, 1'b1);
        abort = 1'b1;
        #1;
        chkb("abort_drain in_ready", in_ready, 1'b0);
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        #2;
        chkb("abort_drain out_valid_after", out_valid, 1'b0);
        chkb("abort_drain busy_after", busy, 1'b0);
        chkb("abort_drain in_ready_after", in_ready, 1'b1);
        tick();

        // Reset in the middle of CALC.
        feed(tbl[0]);
        repeat (5) tick();
        #2;
        chkb("rst_calc busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chkb("rst_calc in_ready_low", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        #2;
        chkb("rst_calc in_ready", in_ready, 1'b1);
        chkb("rst_calc out_valid", out_valid, 1'b0);
        chk("rst_calc out_data", out_data, '0);
        chkb("rst_calc out_last", out_last, 1'b0);
        chkb("rst_calc busy", busy, 1'b0);
        tick();
        run_job(tbl[0], "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
